pid_core: RTL and testbench
===========================

Name: pid_core

Overview:
- Discrete PID compute stage directly downstream of the register file. Consumes gains p/i/d and setpoint sp; produces pid_o_i and feeds it back into the register file.
- On each sample strobe it snapshots setpoint, measurement and gains. It then runs a multi-cycle FSM: error, P, I, D, sum, saturate. It uses one shared multiplier.
- Result is an unsigned 16-bit actuator command consumed by the PWM stage.

Parameters:
- DATA_W, 16, width of gains, setpoint, measurement and output.
- FRAC_BITS, 8, gains are unsigned fixed-point Q(DATA_W-FRAC_BITS).FRAC_BITS.
- INT_W, 20, signed integrator width.
- INT_LIM, 262143, anti-windup clamp magnitude; integrator stays within [-INT_LIM, +INT_LIM]; must fit INT_W.
- ACC_W, 40, signed accumulator width for products and sum.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- p  in  DATA_W  Kp gain (Q8.8 unsigned).
- i  in  DATA_W  Ki gain.
- d  in  DATA_W  Kd gain.
- sp  in  DATA_W  setpoint (unsigned).
- meas_i  in  DATA_W  process measurement (unsigned).
- sample_i  in  1  single-cycle strobe to start one computation.
- clr_i  in  1  synchronous clear of integrator and previous error.
- pid_o  out  DATA_W  registered controller output.
- busy_o  out  1  high while FSM not IDLE.
- done_o  out  1  one-cycle pulse when pid_o updates.
- overrun_o  out  1  sticky: sample_i arrived while busy.

Behaviour:
- Reset (reset==0 at an edge): state IDLE; pid_o=0, done_o=0, busy_o=0, overrun_o=0, integrator=0, e_prev=0; all snapshots=0. Reset mid-computation aborts it with no done_o pulse.
- FSM states: IDLE -> ERR -> PT -> IT -> DT -> OUT -> IDLE. One transition per clock; no stalls.
- IDLE: on sample_i=1, latch p, i, d, sp, meas_i, go ERR. Later register-file writes do not affect the running computation.
- ERR: e = sp - meas (signed DATA_W+1). integ = clamp(integ + e, -INT_LIM, +INT_LIM).
- PT: acc = Kp*e.
- IT: acc += Ki*integ (uses the already-updated integrator).
- DT: acc += Kd*(e - e_prev); e_prev <= e.
- OUT: y = acc >>> FRAC_BITS (arithmetic, floor). pid_o = 0 if y<0, 2^DATA_W-1 if y>2^DATA_W-1, else y. done_o=1 for this cycle only. Return to IDLE.
- Latency: strobe sampled at edge k; pid_o and done_o valid after edge k+5. A new strobe is accepted at edge k+6 (the done cycle is IDLE).
- busy_o = (state != IDLE), registered.
- sample_i while busy: ignored, computation continues, overrun_o set to 1; it clears only on reset.
- clr_i: in IDLE, zeroes integrator and e_prev. If asserted in the same cycle as an accepted sample_i, clear happens first and the sample uses the zeroed state. While busy, clr_i is held pending and applied on the return to IDLE.
- Multiplies are signed: gains zero-extended to signed. All products and sums use ACC_W bits; no intermediate overflow for default widths.

Decomposition:
- Shared package pid_pkg: FSM state encoding (IDLE, ERR, PT, IT, DT, OUT), default DATA_W/FRAC_BITS constants, register index constants shared with the register file (REG_P..REG_PWM_O).
- One sub-module pid_mac: registered signed multiply-accumulate with operand mux select and clear/load control. The FSM drives it once per state.

Test Plan:
- Pure P: p=0x0100, i=0, d=0, sp=1000, meas=400, pulse sample_i -> done_o exactly 5 cycles later; pid_o=600; busy_o high for 5 cycles.
- Saturation: sp=100, meas=500, p=0x0100 -> pid_o=0. Then p=0x2000, sp=60000, meas=0 -> pid_o=65535.
- Integrator: p=0, i=0x0080, sp=10, meas=0, three samples -> pid_o 5, 10, 15. Then clr_i, one sample -> pid_o=5.
- Anti-windup with INT_LIM=100: i=0x0100, e=60, three samples -> pid_o 60, 100, 100. Then e=-30 -> pid_o 70.
- Derivative and snapshot: d=0x0100, p=i=0, e=50, two samples -> pid_o 50 then 0. A write to d during busy does not change the in-flight result.
- Overrun and reset: sample_i at k and k+2 -> single done at k+5, overrun_o=1. reset low at k+3 of a new computation -> no done_o; pid_o=0; overrun_o=0.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared definitions for the PID compute stage: FSM encoding, MAC operand select,
// default widths and register-file indices.
package pid_pkg;

  localparam int PID_DATA_W    = 16;
  localparam int PID_FRAC_BITS = 8;

  // Register-file indices shared with the register file
  localparam int REG_P     = 0;
  localparam int REG_I     = 1;
  localparam int REG_D     = 2;
  localparam int REG_SP    = 3;
  localparam int REG_PID_O = 4;
  localparam int REG_PWM_O = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR  = 3'd1,
    ST_PT   = 3'd2,
    ST_IT   = 3'd3,
    ST_DT   = 3'd4,
    ST_OUT  = 3'd5
  } pid_state_e;

  typedef enum logic [1:0] {
    SEL_E = 2'd0,
    SEL_I = 2'd1,
    SEL_D = 2'd2
  } mac_sel_e;

endpackage

// File: rtl/pid_mac.sv
// Shared signed multiply-accumulate: picks one gain/operand pair per cycle and
// either loads the product or adds it to the running accumulator.
import pid_pkg::*;

module pid_mac #(
  parameter int DATA_W = PID_DATA_W,
  parameter int INT_W  = 20,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic [DATA_W-1:0]        i_kp,
  input  logic [DATA_W-1:0]        i_ki,
  input  logic [DATA_W-1:0]        i_kd,
  input  logic signed [DATA_W:0]   i_e,
  input  logic signed [INT_W-1:0]  i_integ,
  input  logic signed [DATA_W+1:0] i_de,
  input  mac_sel_e                 i_sel,
  input  logic                     i_clr,
  input  logic                     i_load,
  input  logic                     i_acc,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [ACC_W-1:0] w_gain;
  logic signed [ACC_W-1:0] w_opnd;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] r_acc;

  // Gains are unsigned, so zero-extend them; operands are sign-extended
  always_comb begin
    w_gain = '0;
    w_opnd = '0;
    case (i_sel)
      SEL_E: begin
        w_gain = {{(ACC_W-DATA_W){1'b0}}, i_kp};
        w_opnd = {{(ACC_W-DATA_W-1){i_e[DATA_W]}}, i_e};
      end
      SEL_I: begin
        w_gain = {{(ACC_W-DATA_W){1'b0}}, i_ki};
        w_opnd = {{(ACC_W-INT_W){i_integ[INT_W-1]}}, i_integ};
      end
      SEL_D: begin
        w_gain = {{(ACC_W-DATA_W){1'b0}}, i_kd};
        w_opnd = {{(ACC_W-DATA_W-2){i_de[DATA_W+1]}}, i_de};
      end
      default: begin
        w_gain = '0;
        w_opnd = '0;
      end
    endcase
  end

  assign w_prod = w_gain * w_opnd;

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_clr) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_prod;
    end else if (i_acc) begin
      r_acc <= r_acc + w_prod;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/pid_core.sv
// Discrete PID compute stage: snapshots inputs on a sample strobe, then runs
// ERR -> P -> I -> D -> OUT through one shared MAC and saturates to an unsigned command.
import pid_pkg::*;

module pid_core #(
  parameter int DATA_W    = PID_DATA_W,
  parameter int FRAC_BITS = PID_FRAC_BITS,
  parameter int INT_W     = 20,
  parameter int INT_LIM   = 262143,
  parameter int ACC_W     = 40
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [DATA_W-1:0] p,
  input  logic [DATA_W-1:0] i,
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] sp,
  input  logic [DATA_W-1:0] meas_i,
  input  logic              sample_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] pid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o
);

  localparam logic signed [INT_W:0]   LIM_POS = (INT_W+1)'(INT_LIM);
  localparam logic signed [INT_W:0]   LIM_NEG = -LIM_POS;
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  pid_state_e r_state, w_next;

  logic [DATA_W-1:0]        r_kp, r_ki, r_kd, r_sp, r_meas;
  logic signed [DATA_W:0]   r_e, r_e_prev;
  logic signed [INT_W-1:0]  r_integ;
  logic                     r_clr_pend;
  logic [DATA_W-1:0]        r_pid;
  logic                     r_done;
  logic                     r_overrun;

  logic signed [DATA_W:0]   w_e;
  logic signed [INT_W:0]    w_integ_sum;
  logic signed [DATA_W+1:0] w_de;
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [ACC_W-1:0]  w_y;
  mac_sel_e                 w_sel;
  logic                     w_mac_load, w_mac_acc;

  function automatic logic signed [INT_W-1:0] clamp_integ(input logic signed [INT_W:0] v);
    if (v > LIM_POS)      return LIM_POS[INT_W-1:0];
    else if (v < LIM_NEG) return LIM_NEG[INT_W-1:0];
    else                  return v[INT_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    if (v < 0)            return '0;
    else if (v > OUT_MAX) return {DATA_W{1'b1}};
    else                  return v[DATA_W-1:0];
  endfunction

  assign w_e         = $signed({1'b0, r_sp}) - $signed({1'b0, r_meas});
  assign w_integ_sum = {r_integ[INT_W-1], r_integ} + {{(INT_W-DATA_W){w_e[DATA_W]}}, w_e};
  assign w_de        = {r_e[DATA_W], r_e} - {r_e_prev[DATA_W], r_e_prev};
  assign w_y         = w_acc >>> FRAC_BITS;

  always_ff @(posedge clk_in) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (sample_i) w_next = ST_ERR;
      ST_ERR:  w_next = ST_PT;
      ST_PT:   w_next = ST_IT;
      ST_IT:   w_next = ST_DT;
      ST_DT:   w_next = ST_OUT;
      ST_OUT:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel      = SEL_E;
    w_mac_load = 1'b0;
    w_mac_acc  = 1'b0;
    case (r_state)
      ST_PT: w_mac_load = 1'b1;
      ST_IT: begin w_sel = SEL_I; w_mac_acc = 1'b1; end
      ST_DT: begin w_sel = SEL_D; w_mac_acc = 1'b1; end
      default: ;
    endcase
  end

  // A clear requested mid-computation is deferred to the next IDLE cycle, where it
  // also precedes any sample accepted in that same cycle.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_kp <= '0; r_ki <= '0; r_kd <= '0; r_sp <= '0; r_meas <= '0;
      r_e <= '0; r_e_prev <= '0; r_integ <= '0;
      r_clr_pend <= 1'b0; r_pid <= '0; r_done <= 1'b0; r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (sample_i && r_state != ST_IDLE) r_overrun <= 1'b1;
      if (clr_i && r_state != ST_IDLE)    r_clr_pend <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (clr_i || r_clr_pend) begin
            r_integ    <= '0;
            r_e_prev   <= '0;
            r_clr_pend <= 1'b0;
          end
          if (sample_i) begin
            r_kp <= p; r_ki <= i; r_kd <= d; r_sp <= sp; r_meas <= meas_i;
          end
        end
        ST_ERR: begin
          r_e     <= w_e;
          r_integ <= clamp_integ(w_integ_sum);
        end
        ST_DT:  r_e_prev <= r_e;
        ST_OUT: begin
          r_pid  <= sat_out(w_y);
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  pid_mac #(
    .DATA_W (DATA_W),
    .INT_W  (INT_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk_in),
    .i_rst_n (reset),
    .i_kp    (r_kp),
    .i_ki    (r_ki),
    .i_kd    (r_kd),
    .i_e     (r_e),
    .i_integ (r_integ),
    .i_de    (w_de),
    .i_sel   (w_sel),
    .i_clr   (1'b0),
    .i_load  (w_mac_load),
    .i_acc   (w_mac_acc),
    .o_acc   (w_acc)
  );

  assign pid_o     = r_pid;
  assign busy_o    = (r_state != ST_IDLE);
  assign done_o    = r_done;
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_pid_core.sv
// Directed bench for pid_core: a vector table of single samples plus hand-written
// multi-cycle sequences for snapshot, deferred clear, overrun and mid-flight reset.
module tb_pid_core;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [15:0] p, i, d, sp, meas_i;
  logic        sample_i, clr_i;
  logic [15:0] pid_o;
  logic        busy_o, done_o, overrun_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  pid_core #(.INT_LIM(100)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .p         (p),
    .i         (i),
    .d         (d),
    .sp        (sp),
    .meas_i    (meas_i),
    .sample_i  (sample_i),
    .clr_i     (clr_i),
    .pid_o     (pid_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .overrun_o (overrun_o)
  );

  typedef struct {
    logic [15:0] p, i, d, sp, meas;
    logic        clr;
    int          exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Counts edges until done_o is seen; busy cycles counted before each edge
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int n = 1; n <= 12; n++) begin
      if (busy_o) bcnt++;
      @(posedge clk_in); #1;
      if (done_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic pulse(input logic clr);
    @(posedge clk_in); #1;
    sample_i = 1'b1;
    clr_i    = clr;
    @(posedge clk_in); #1;
    sample_i = 1'b0;
    clr_i    = 1'b0;
  endtask

  task automatic do_sample(input logic clr, output int lat, output int bcnt);
    pulse(clr);
    wait_done(lat, bcnt);
  endtask

  int lat, bcnt, ndone, first_at;

  initial begin
    vecs[0]  = '{16'h0100, 16'h0000, 16'h0000, 16'd1000,  16'd400, 1'b0, 600};
    vecs[1]  = '{16'h0100, 16'h0000, 16'h0000, 16'd100,   16'd500, 1'b0, 0};
    vecs[2]  = '{16'h2000, 16'h0000, 16'h0000, 16'd60000, 16'd0,   1'b0, 65535};
    vecs[3]  = '{16'h0000, 16'h0080, 16'h0000, 16'd10,    16'd0,   1'b1, 5};
    vecs[4]  = '{16'h0000, 16'h0080, 16'h0000, 16'd10,    16'd0,   1'b0, 10};
    vecs[5]  = '{16'h0000, 16'h0080, 16'h0000, 16'd10,    16'd0,   1'b0, 15};
    vecs[6]  = '{16'h0000, 16'h0080, 16'h0000, 16'd10,    16'd0,   1'b1, 5};
    vecs[7]  = '{16'h0000, 16'h0100, 16'h0000, 16'd60,    16'd0,   1'b1, 60};
    vecs[8]  = '{16'h0000, 16'h0100, 16'h0000, 16'd60,    16'd0,   1'b0, 100};
    vecs[9]  = '{16'h0000, 16'h0100, 16'h0000, 16'd60,    16'd0,   1'b0, 100};
    vecs[10] = '{16'h0000, 16'h0100, 16'h0000, 16'd0,     16'd30,  1'b0, 70};
    vecs[11] = '{16'h0000, 16'h0000, 16'h0100, 16'd50,    16'd0,   1'b1, 50};
    vecs[12] = '{16'h0000, 16'h0000, 16'h0100, 16'd50,    16'd0,   1'b0, 0};

    reset = 1'b0; sample_i = 1'b0; clr_i = 1'b0;
    p = '0; i = '0; d = '0; sp = '0; meas_i = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_pid", pid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_overrun", overrun_o, 0);
    reset = 1'b1;

    for (int k = 0; k < 13; k++) begin
      p = vecs[k].p; i = vecs[k].i; d = vecs[k].d;
      sp = vecs[k].sp; meas_i = vecs[k].meas;
      do_sample(vecs[k].clr, lat, bcnt);
      check($sformatf("vec%0d_latency", k), lat, 5);
      check($sformatf("vec%0d_busy_cycles", k), bcnt, 5);
      check($sformatf("vec%0d_pid", k), pid_o, vecs[k].exp);
      @(posedge clk_in); #1;
      check($sformatf("vec%0d_done_width", k), done_o, 0);
    end

    // Snapshot: e_prev=50, e=80 -> 30; later writes to d/sp/meas must not leak in
    sp = 16'd80; meas_i = 16'd0;
    pulse(1'b0);
    @(posedge clk_in); #1;
    d = 16'h0200; sp = 16'd0; meas_i = 16'd999;
    wait_done(lat, bcnt);
    check("snap_latency", lat, 4);
    check("snap_pid", pid_o, 30);

    // Deferred clear: this run still sees e_prev=80 (50-80 -> 0), the next sees e_prev=0
    p = 16'h0000; i = 16'h0000; d = 16'h0100; sp = 16'd50; meas_i = 16'd0;
    pulse(1'b0);
    @(posedge clk_in); #1;
    clr_i = 1'b1;
    @(posedge clk_in); #1;
    clr_i = 1'b0;
    wait_done(lat, bcnt);
    check("pend_clr_latency", lat, 3);
    check("pend_clr_pid_a", pid_o, 0);
    do_sample(1'b0, lat, bcnt);
    check("pend_clr_pid_b", pid_o, 50);

    // Overrun: second strobe two cycles in is ignored
    p = 16'h0100; i = 16'h0000; d = 16'h0000; sp = 16'd50; meas_i = 16'd0;
    check("overrun_before", overrun_o, 0);
    pulse(1'b0);
    @(posedge clk_in); #1;
    sample_i = 1'b1;
    @(posedge clk_in); #1;
    sample_i = 1'b0;
    ndone = 0; first_at = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk_in); #1;
      if (done_o) begin
        ndone++;
        if (first_at < 0) first_at = n;
      end
    end
    check("overrun_first_done", first_at, 3);
    check("overrun_done_count", ndone, 1);
    check("overrun_flag", overrun_o, 1);
    check("overrun_pid", pid_o, 50);

    // Reset in the middle of a computation
    sp = 16'd1000;
    pulse(1'b0);
    @(posedge clk_in);
    @(posedge clk_in); #1;
    reset = 1'b0;
    @(posedge clk_in); #1;
    reset = 1'b1;
    check("midrst_pid", pid_o, 0);
    check("midrst_overrun", overrun_o, 0);
    check("midrst_busy", busy_o, 0);
    ndone = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk_in); #1;
      if (done_o) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    // Integrator must be zero after reset: 0 + 10 -> 10 with Ki=1.0
    p = 16'h0000; i = 16'h0100; d = 16'h0000; sp = 16'd10; meas_i = 16'd0;
    do_sample(1'b0, lat, bcnt);
    check("post_rst_latency", lat, 5);
    check("post_rst_integ", pid_o, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
